// File: rtl/sprite_sdr_pkg.sv
// ============================================================================
// Module      : sprite_sdr_pkg
// Description : Shared types and constants for the sprite SDRAM read arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sprite_sdr_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_t;

    localparam int REQ_GA21   = 0;
    localparam int REQ_RENDER = 1;

    localparam int DEFAULT_AW = 25;
    localparam int DEFAULT_DW = 64;

endpackage

`default_nettype wire

// File: rtl/sprite_sdr_arbiter_rr_pick2.sv
// ============================================================================
// Module      : rr_pick2
// Description : Combinational two-way round-robin pick from pending/last_grant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick2 (
    input  logic [1:0] pending,
    input  logic       last_grant,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |pending;
        // With both pending the channel that did not win last time goes next.
        if (&pending) begin
            grant = ~last_grant;
        end else begin
            grant = pending[1];
        end
    end

endmodule

`default_nettype wire

// File: rtl/sprite_sdr_arbiter.sv
// ============================================================================
// Module      : sprite_sdr_arbiter
// Description : Shares one SDRAM read channel between the GA21 sprite-table
//               fetch and the sprite renderer tile fetch, one read in flight.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_sdr_arbiter
    import sprite_sdr_pkg::*;
#(
    parameter int AW      = DEFAULT_AW,
    parameter int DW      = DEFAULT_DW,
    parameter int TIMEOUT = 1023
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    output logic [1:0]    rdy,
    output logic [DW-1:0] dout,
    output logic          sdr_req,
    output logic [AW-1:0] sdr_addr,
    input  logic [DW-1:0] sdr_data,
    input  logic          sdr_rdy,
    output logic          timeout_err
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_t    state_q, state_d;
    logic [1:0]    pending_q, pending_d;
    logic [AW-1:0] pend_addr0_q, pend_addr0_d;
    logic [AW-1:0] pend_addr1_q, pend_addr1_d;
    logic          last_grant_q, last_grant_d;
    logic [1:0]    rdy_q, rdy_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          sdr_req_q, sdr_req_d;
    logic [AW-1:0] sdr_addr_q, sdr_addr_d;
    logic          timeout_err_q, timeout_err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [1:0]    w_eff_pend;
    logic          w_grant;
    logic          w_any;
    logic [AW-1:0] w_grant_addr;
    logic          w_timeout;

    // Live request pulses are folded in so an idle arbiter issues next cycle.
    assign w_eff_pend = pending_q | req;

    rr_pick2 u_pick (
        .pending    (w_eff_pend),
        .last_grant (last_grant_q),
        .grant      (w_grant),
        .valid      (w_any)
    );

    always_comb begin
        if (w_grant) begin
            w_grant_addr = req[1] ? addr1 : pend_addr1_q;
        end else begin
            w_grant_addr = req[0] ? addr0 : pend_addr0_q;
        end
    end

    assign w_timeout = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pending_q     <= 2'b00;
            pend_addr0_q  <= '0;
            pend_addr1_q  <= '0;
            last_grant_q  <= 1'b1;
            rdy_q         <= 2'b00;
            dout_q        <= '0;
            sdr_req_q     <= 1'b0;
            sdr_addr_q    <= '0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            pend_addr0_q  <= pend_addr0_d;
            pend_addr1_q  <= pend_addr1_d;
            last_grant_q  <= last_grant_d;
            rdy_q         <= rdy_d;
            dout_q        <= dout_d;
            sdr_req_q     <= sdr_req_d;
            sdr_addr_q    <= sdr_addr_d;
            timeout_err_q <= timeout_err_d;
            cnt_q         <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (w_any) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (sdr_rdy || w_timeout) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath logic
    always_comb begin
        pending_d     = pending_q | req;
        pend_addr0_d  = req[0] ? addr0 : pend_addr0_q;
        pend_addr1_d  = req[1] ? addr1 : pend_addr1_q;
        last_grant_d  = last_grant_q;
        rdy_d         = rdy_q & ~req;
        dout_d        = dout_q;
        sdr_req_d     = 1'b0;
        sdr_addr_d    = sdr_addr_q;
        timeout_err_d = timeout_err_q;
        cnt_d         = cnt_q;
        case (state_q)
            IDLE: begin
                if (w_any) begin
                    sdr_req_d          = 1'b1;
                    sdr_addr_d         = w_grant_addr;
                    pending_d[w_grant] = 1'b0;
                    last_grant_d       = w_grant;
                    cnt_d              = '0;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (sdr_rdy) begin
                    dout_d = sdr_data;
                    // A re-request of the in-flight channel supersedes its data.
                    if (!pending_q[last_grant_q] && !req[last_grant_q]) begin
                        rdy_d[last_grant_q] = 1'b1;
                    end
                end else if (w_timeout) begin
                    timeout_err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign rdy         = rdy_q;
    assign dout        = dout_q;
    assign sdr_req     = sdr_req_q;
    assign sdr_addr    = sdr_addr_q;
    assign timeout_err = timeout_err_q;

endmodule

`default_nettype wire
